// File: rtl/csr_bus_router.sv
// -----------------------------------------------------------------------------
// csr_bus_router
//
// Routes one CSR access at a time from the CSR execute stage to one of
// NUM_TGT CSR-owning blocks. The address is decoded against per-target
// inclusive [base, limit] windows; the lowest-index hit wins. The access is
// presented to the selected target for one strobe cycle, the router then waits
// for that target's read valid (bounded by TIMEOUT), and the result is held on
// the response channel until the consumer accepts it. Unmapped addresses and
// timeouts answer with rdata=0 and the exception flag set, and bump a
// saturating 8-bit error counter.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   csr_valid/ready request handshake (ready only in IDLE)
//   csr_op/funct3/imm/rs1_val/addr   request fields, latched on acceptance
//   csr_rvalid/rready                response handshake
//   csr_rdata/reg_rsp                response data and exception flag
//   err_cnt         saturating count of unmapped and timeout responses
//   tgt_reg_en      one-hot access strobe, REQ cycle only
//   tgt_addr/reg_op/funct3/csr_imm/rs1_val  per-target slices, selected
//                   target only, REQ through WAIT; zero elsewhere
//   tgt_rvalid/rdata/act_rsp         per-target response
//   tgt_rrsp        one-cycle ack to the target whose response was captured
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a request; decode and latch on csr_valid
// REQ   | single strobe cycle to the selected target
// WAIT  | waiting for tgt_rvalid[sel], timeout counter running
// RSP   | response held on csr_rvalid until csr_rready
// -----------------------------------------------------------------------------
module csr_bus_router #(
   parameter int ADDR_WIDTH = 32,
   parameter int REG_WIDTH  = 32,
   parameter int NUM_TGT    = 4,
   parameter int TIMEOUT    = 16,
   parameter logic [NUM_TGT*ADDR_WIDTH-1:0] TGT_BASE  =
      {32'h0000_0F11, 32'h0000_07A0, 32'h0000_0300, 32'h0000_03A0},
   parameter logic [NUM_TGT*ADDR_WIDTH-1:0] TGT_LIMIT =
      {32'h0000_0F14, 32'h0000_07AF, 32'h0000_03FF, 32'h0000_03EF}
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            csr_valid,
   output logic                            csr_ready,
   input  logic [1:0]                      csr_op,
   input  logic [2:0]                      csr_funct3,
   input  logic [4:0]                      csr_imm,
   input  logic [REG_WIDTH-1:0]            rs1_val,
   input  logic [ADDR_WIDTH-1:0]           csr_addr,
   output logic                            csr_rvalid,
   input  logic                            csr_rready,
   output logic [REG_WIDTH-1:0]            csr_rdata,
   output logic                            csr_reg_rsp,
   output logic [7:0]                      err_cnt,
   output logic [NUM_TGT-1:0]              tgt_reg_en,
   output logic [NUM_TGT*ADDR_WIDTH-1:0]   tgt_addr,
   output logic [NUM_TGT*2-1:0]            tgt_reg_op,
   output logic [NUM_TGT*3-1:0]            tgt_funct3,
   output logic [NUM_TGT*5-1:0]            tgt_csr_imm,
   output logic [NUM_TGT*REG_WIDTH-1:0]    tgt_rs1_val,
   input  logic [NUM_TGT-1:0]              tgt_rvalid,
   input  logic [NUM_TGT*REG_WIDTH-1:0]    tgt_rdata,
   input  logic [NUM_TGT-1:0]              tgt_act_rsp,
   output logic [NUM_TGT-1:0]              tgt_rrsp
);

   localparam int SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RSP  = 2'd3
   } state_t;

   state_t                  state_q;
   logic [1:0]              op_q;
   logic [2:0]              funct3_q;
   logic [4:0]              imm_q;
   logic [REG_WIDTH-1:0]    rs1_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [SEL_W-1:0]        sel_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic [REG_WIDTH-1:0]    rdata_q;
   logic                    reg_rsp_q;
   logic [7:0]              err_cnt_q;
   logic [7:0]              err_cnt_d;

   logic                    hit_any;
   logic [SEL_W-1:0]        hit_idx;
   logic                    sel_rvalid;
   logic [REG_WIDTH-1:0]    sel_rdata;
   logic                    sel_act;

   // Scan from the top index down so the lowest matching window is the one
   // left standing when windows overlap.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int i = NUM_TGT - 1; i >= 0; i--) begin
         if ((csr_addr >= TGT_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
             (csr_addr <= TGT_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
            hit_any = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   // Only the selected target's response lines are looked at.
   always_comb begin
      sel_rvalid = 1'b0;
      sel_rdata  = '0;
      sel_act    = 1'b0;
      for (int i = 0; i < NUM_TGT; i++) begin
         if (sel_q == SEL_W'(i)) begin
            sel_rvalid = tgt_rvalid[i];
            sel_rdata  = tgt_rdata[i*REG_WIDTH +: REG_WIDTH];
            sel_act    = tgt_act_rsp[i];
         end
      end
   end

   assign cnt_d     = cnt_q + CNT_W'(1);
   assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         funct3_q  <= '0;
         imm_q     <= '0;
         rs1_q     <= '0;
         addr_q    <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         reg_rsp_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (csr_valid) begin
                  op_q     <= csr_op;
                  funct3_q <= csr_funct3;
                  imm_q    <= csr_imm;
                  rs1_q    <= rs1_val;
                  addr_q   <= csr_addr;
                  sel_q    <= hit_idx;
                  if (hit_any) begin
                     state_q <= S_REQ;
                  end else begin
                     rdata_q   <= '0;
                     reg_rsp_q <= 1'b1;
                     err_cnt_q <= err_cnt_d;
                     state_q   <= S_RSP;
                  end
               end
            end
            S_REQ: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // rvalid is tested first so it wins over a coincident timeout.
               if (sel_rvalid) begin
                  rdata_q   <= sel_rdata;
                  reg_rsp_q <= sel_act;
                  state_q   <= S_RSP;
               end else if (cnt_q == CNT_LAST) begin
                  rdata_q   <= '0;
                  reg_rsp_q <= 1'b1;
                  err_cnt_q <= err_cnt_d;
                  state_q   <= S_RSP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_RSP: begin
               if (csr_rready) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign csr_ready   = (state_q == S_IDLE);
   assign csr_rvalid  = (state_q == S_RSP);
   assign csr_rdata   = rdata_q;
   assign csr_reg_rsp = reg_rsp_q;
   assign err_cnt     = err_cnt_q;

   // Target-side fan-out. tgt_rrsp is qualified by WAIT so a late rvalid
   // after a timeout never gets acknowledged.
   always_comb begin
      tgt_reg_en  = '0;
      tgt_addr    = '0;
      tgt_reg_op  = '0;
      tgt_funct3  = '0;
      tgt_csr_imm = '0;
      tgt_rs1_val = '0;
      tgt_rrsp    = '0;
      for (int i = 0; i < NUM_TGT; i++) begin
         if (sel_q == SEL_W'(i)) begin
            if (state_q == S_REQ) begin
               tgt_reg_en[i] = 1'b1;
            end
            if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
               tgt_addr[i*ADDR_WIDTH +: ADDR_WIDTH]   = addr_q;
               tgt_reg_op[i*2 +: 2]                   = op_q;
               tgt_funct3[i*3 +: 3]                   = funct3_q;
               tgt_csr_imm[i*5 +: 5]                  = imm_q;
               tgt_rs1_val[i*REG_WIDTH +: REG_WIDTH]  = rs1_q;
            end
            if (state_q == S_WAIT) begin
               tgt_rrsp[i] = tgt_rvalid[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_csr_bus_router.sv
module tb_csr_bus_router;

   localparam int AW = 32;
   localparam int RW = 32;
   localparam int NT = 4;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            csr_valid = 1'b0;
   logic            csr_ready;
   logic [1:0]      csr_op = '0;
   logic [2:0]      csr_funct3 = '0;
   logic [4:0]      csr_imm = '0;
   logic [RW-1:0]   rs1_val = '0;
   logic [AW-1:0]   csr_addr = '0;
   logic            csr_rvalid;
   logic            csr_rready = 1'b0;
   logic [RW-1:0]   csr_rdata;
   logic            csr_reg_rsp;
   logic [7:0]      err_cnt;
   logic [NT-1:0]   tgt_reg_en;
   logic [NT*AW-1:0] tgt_addr;
   logic [NT*2-1:0] tgt_reg_op;
   logic [NT*3-1:0] tgt_funct3;
   logic [NT*5-1:0] tgt_csr_imm;
   logic [NT*RW-1:0] tgt_rs1_val;
   logic [NT-1:0]   tgt_rvalid = '0;
   logic [NT*RW-1:0] tgt_rdata = '0;
   logic [NT-1:0]   tgt_act_rsp = '0;
   logic [NT-1:0]   tgt_rrsp;

   csr_bus_router #(.ADDR_WIDTH(AW), .REG_WIDTH(RW), .NUM_TGT(NT), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .csr_valid(csr_valid), .csr_ready(csr_ready),
      .csr_op(csr_op), .csr_funct3(csr_funct3), .csr_imm(csr_imm),
      .rs1_val(rs1_val), .csr_addr(csr_addr),
      .csr_rvalid(csr_rvalid), .csr_rready(csr_rready),
      .csr_rdata(csr_rdata), .csr_reg_rsp(csr_reg_rsp), .err_cnt(err_cnt),
      .tgt_reg_en(tgt_reg_en), .tgt_addr(tgt_addr), .tgt_reg_op(tgt_reg_op),
      .tgt_funct3(tgt_funct3), .tgt_csr_imm(tgt_csr_imm), .tgt_rs1_val(tgt_rs1_val),
      .tgt_rvalid(tgt_rvalid), .tgt_rdata(tgt_rdata), .tgt_act_rsp(tgt_act_rsp),
      .tgt_rrsp(tgt_rrsp)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int err_m  = 0;

   logic [AW-1:0] win_base  [NT] = '{32'h3A0, 32'h300, 32'h7A0, 32'hF11};
   logic [AW-1:0] win_limit [NT] = '{32'h3EF, 32'h3FF, 32'h7AF, 32'hF14};

   // Fields of the request currently in flight, used to build expected slices.
   logic [AW-1:0] cur_addr;
   logic [1:0]    cur_op;
   logic [2:0]    cur_f3;
   logic [4:0]    cur_imm;
   logic [RW-1:0] cur_rs1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_tgt(input logic [AW-1:0] a);
      for (int i = 0; i < NT; i++)
         if (a >= win_base[i] && a <= win_limit[i]) return i;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_tgt(input int t, input bit in_flight, input bit en, input bit rr);
      logic [NT-1:0]    e_en;
      logic [NT-1:0]    e_rr;
      logic [NT*AW-1:0] e_addr;
      logic [NT*2-1:0]  e_op;
      logic [NT*3-1:0]  e_f3;
      logic [NT*5-1:0]  e_imm;
      logic [NT*RW-1:0] e_rs1;
      e_en = '0; e_rr = '0; e_addr = '0; e_op = '0; e_f3 = '0; e_imm = '0; e_rs1 = '0;
      if (t >= 0 && in_flight) begin
         e_addr[t*AW +: AW] = cur_addr;
         e_op[t*2 +: 2]     = cur_op;
         e_f3[t*3 +: 3]     = cur_f3;
         e_imm[t*5 +: 5]    = cur_imm;
         e_rs1[t*RW +: RW]  = cur_rs1;
      end
      if (t >= 0 && en) e_en[t] = 1'b1;
      if (t >= 0 && rr) e_rr[t] = 1'b1;
      chk("tgt_reg_en", 128'(tgt_reg_en), 128'(e_en));
      chk("tgt_rrsp", 128'(tgt_rrsp), 128'(e_rr));
      chk("tgt_addr", 128'(tgt_addr), 128'(e_addr));
      chk("tgt_reg_op", 128'(tgt_reg_op), 128'(e_op));
      chk("tgt_funct3", 128'(tgt_funct3), 128'(e_f3));
      chk("tgt_csr_imm", 128'(tgt_csr_imm), 128'(e_imm));
      chk("tgt_rs1_val", 128'(tgt_rs1_val), 128'(e_rs1));
   endtask

   // delay: WAIT cycle (0-based) in which the target answers; -1 = silent.
   // hold: number of RSP cycles with csr_rready low before acceptance.
   task automatic run_txn(input logic [AW-1:0] addr, input logic [1:0] op,
                          input logic [2:0] f3, input logic [4:0] imm,
                          input logic [RW-1:0] rs1, input int delay,
                          input logic [RW-1:0] data, input logic act, input int hold);
      int t, lat, err_prev;
      bit err_rsp, answered;
      logic [RW-1:0] e_data;
      logic e_flag;
      t = model_tgt(addr);
      answered = (delay >= 0) && (delay < TO);
      if (t < 0)        begin lat = 1;        err_rsp = 1'b1; end
      else if (answered) begin lat = 3 + delay; err_rsp = 1'b0; end
      else              begin lat = 2 + TO;   err_rsp = 1'b1; end
      e_data = err_rsp ? '0 : data;
      e_flag = err_rsp ? 1'b1 : act;
      err_prev = err_m;
      if (err_rsp) err_m = (err_m < 255) ? err_m + 1 : 255;

      tick();
      csr_valid = 1'b1; csr_addr = addr; csr_op = op; csr_funct3 = f3;
      csr_imm = imm; rs1_val = rs1;
      cur_addr = addr; cur_op = op; cur_f3 = f3; cur_imm = imm; cur_rs1 = rs1;
      #1;
      chk("accept_ready", 128'(csr_ready), 128'(1));
      chk("accept_rvalid", 128'(csr_rvalid), 128'(0));

      for (int n = 1; n < lat; n++) begin
         tick();
         csr_valid = 1'($urandom_range(0, 1));
         csr_addr = $urandom; csr_op = 2'($urandom); csr_funct3 = 3'($urandom);
         csr_imm = 5'($urandom); rs1_val = $urandom;
         tgt_rvalid = NT'($urandom);
         tgt_rdata = {$urandom, $urandom, $urandom, $urandom};
         tgt_act_rsp = NT'($urandom);
         if (n == 1) tgt_rvalid[t] = 1'($urandom_range(0, 1));
         else        tgt_rvalid[t] = answered && (n == 2 + delay);
         if (answered && n == 2 + delay) begin
            tgt_rdata[t*RW +: RW] = data;
            tgt_act_rsp[t] = act;
         end
         #1;
         chk("busy_ready", 128'(csr_ready), 128'(0));
         chk("busy_rvalid", 128'(csr_rvalid), 128'(0));
         chk("busy_err_cnt", 128'(err_cnt), 128'(err_prev));
         check_tgt(t, 1'b1, n == 1, answered && (n == 2 + delay));
      end

      for (int h = 0; h <= hold; h++) begin
         tick();
         csr_valid = 1'($urandom_range(0, 1));
         csr_addr = $urandom;
         csr_rready = (h == hold);
         tgt_rvalid = NT'($urandom);
         tgt_rdata = {$urandom, $urandom, $urandom, $urandom};
         if (t >= 0 && !answered) tgt_rvalid[t] = 1'b1;
         #1;
         chk("rsp_rvalid", 128'(csr_rvalid), 128'(1));
         chk("rsp_ready", 128'(csr_ready), 128'(0));
         chk("rsp_rdata", 128'(csr_rdata), 128'(e_data));
         chk("rsp_reg_rsp", 128'(csr_reg_rsp), 128'(e_flag));
         chk("rsp_err_cnt", 128'(err_cnt), 128'(err_m));
         check_tgt(t, 1'b0, 1'b0, 1'b0);
      end

      tick();
      csr_valid = 1'b0; csr_rready = 1'b0; tgt_rvalid = '0;
      #1;
      chk("back_idle_ready", 128'(csr_ready), 128'(1));
      chk("back_idle_rvalid", 128'(csr_rvalid), 128'(0));
   endtask

   function automatic logic [AW-1:0] pick_addr();
      int k, t;
      t = $urandom_range(0, NT - 1);
      k = $urandom_range(0, 3);
      case (k)
         0: return win_base[t] + AW'($urandom_range(0, 32'(win_limit[t] - win_base[t])));
         1: case ($urandom_range(0, 3))
               0: return win_base[t];
               1: return win_limit[t];
               2: return win_base[t] - 1;
               default: return win_limit[t] + 1;
            endcase
         2: return $urandom;
         default: return 32'h3A0 + AW'($urandom_range(0, 32'h4F));
      endcase
   endfunction

   initial begin
      int d;
      logic [AW-1:0] a;

      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("reset_ready", 128'(csr_ready), 128'(1));
      chk("reset_rvalid", 128'(csr_rvalid), 128'(0));
      chk("reset_rdata", 128'(csr_rdata), 128'(0));
      chk("reset_reg_rsp", 128'(csr_reg_rsp), 128'(0));
      chk("reset_err_cnt", 128'(err_cnt), 128'(0));
      check_tgt(-1, 1'b0, 1'b0, 1'b0);

      // Overlap: 0x3B0 sits in tgt0 and tgt1, tgt0 answers immediately.
      run_txn(32'h3B0, 2'b10, 3'd2, 5'd3, 32'h1234_5678, 0, 32'hDEAD_BEEF, 1'b0, 0);
      // Unmapped.
      run_txn(32'h800, 2'b01, 3'd1, 5'd0, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, 0);
      // Silent tgt2 -> timeout, late rvalid ignored.
      run_txn(32'h7A4, 2'b11, 3'd3, 5'd7, 32'h0BAD_F00D, -1, 32'h0, 1'b0, 2);
      // tgt1 exception with consumer back-pressure.
      run_txn(32'h305, 2'b10, 3'd6, 5'd31, 32'hFFFF_0000, 2, 32'hCAFE_0001, 1'b1, 5);
      // rvalid in the very cycle the timeout would fire wins.
      run_txn(32'hF14, 2'b00, 3'd5, 5'd9, 32'h0000_0042, TO - 1, 32'h5555_AAAA, 1'b0, 1);

      for (int i = 0; i < 40; i++) begin
         d = $urandom_range(0, TO + 3);
         if (d >= TO) d = -1;
         run_txn(pick_addr(), 2'($urandom), 3'($urandom), 5'($urandom), $urandom,
                 d, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      // Reset in WAIT for tgt3: transaction vanishes.
      tick();
      csr_valid = 1'b1; csr_addr = 32'hF12; csr_op = 2'b10; csr_funct3 = 3'd2;
      csr_imm = 5'd1; rs1_val = 32'h1;
      tick();
      csr_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      err_m = 0;
      #1;
      chk("midrst_ready", 128'(csr_ready), 128'(1));
      chk("midrst_rvalid", 128'(csr_rvalid), 128'(0));
      chk("midrst_rdata", 128'(csr_rdata), 128'(0));
      chk("midrst_reg_rsp", 128'(csr_reg_rsp), 128'(0));
      chk("midrst_err_cnt", 128'(err_cnt), 128'(0));
      check_tgt(-1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         tgt_rvalid = 4'b1000;
         #1;
         chk("post_rst_no_rsp", 128'(csr_rvalid), 128'(0));
         chk("post_rst_no_rrsp", 128'(tgt_rrsp), 128'(0));
      end
      tgt_rvalid = '0;

      // Saturation of the error counter.
      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         if (model_tgt(a) >= 0) a = 32'h800;
         run_txn(a, 2'($urandom), 3'($urandom), 5'($urandom), $urandom, 0, 32'h0, 1'b0, 0);
      end
      chk("err_cnt_saturated", 128'(err_cnt), 128'(255));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
